// File: rtl/alu_ops_pkg.sv
// Shared definitions for the ALU execute stage.
// Holds the 4-bit ALU operation code (also imported by the controller decode),
// the execute FSM state encoding and small classification helpers.
package alu_ops_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_EQ   = 4'b1000,
    OP_NE   = 4'b1001,
    OP_SUB  = 4'b1010,
    OP_LT   = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_GE   = 4'b1101,
    OP_LTU  = 4'b1110,
    OP_GEU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // Shifts are the only multi-cycle operations.
  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Compares produce a single condition bit zero-extended to the result width.
  function automatic logic is_cmp(alu_op_e op);
    return (op == OP_SLTU) || (op == OP_EQ)  || (op == OP_NE)  ||
           (op == OP_LT)   || (op == OP_SLT) || (op == OP_GE)  ||
           (op == OP_LTU)  || (op == OP_GEU);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational single-cycle ALU operations: logic, add/sub, compares.
// Ports:
//   op   in  4      operation code (alu_op_e encoding)
//   a    in  WIDTH  operand A
//   b    in  WIDTH  operand B
//   res  out WIDTH  result; shift codes return 0 (handled by the sequencer)
module alu_comb_core
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  alu_op_e op_e;
  logic    cond;

  assign op_e = alu_op_e'(op);

  always_comb begin
    cond = 1'b0;
    res  = '0;
    case (op_e)
      OP_AND:          res  = a & b;
      OP_OR:           res  = a | b;
      OP_XOR:          res  = a ^ b;
      OP_ADD:          res  = a + b;
      OP_SUB:          res  = a - b;
      OP_EQ:           cond = (a == b);
      OP_NE:           cond = (a != b);
      OP_LT, OP_SLT:   cond = ($signed(a) < $signed(b));
      OP_GE:           cond = ($signed(a) >= $signed(b));
      OP_LTU, OP_SLTU: cond = (a < b);
      OP_GEU:          cond = (a >= b);
      default:         res  = '0;
    endcase
    if (is_cmp(op_e)) begin
      res = {{(WIDTH-1){1'b0}}, cond};
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with an iterative 1-bit/cycle shifter.
// Handshake: an input op is taken on a rising edge where in_valid & in_ready
// & ~flush; a result is consumed on a rising edge where out_valid & out_ready.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     op/operand handshake (in_ready = state is IDLE)
//   op, a, b              operation, operands (shift amount = low bits of b)
//   flush                 synchronous kill of any in-flight or held op
//   out_valid/out_ready   result handshake (out_valid = state is DONE)
//   result, zero          registered result and (result == 0)
//   busy                  state != IDLE
//   state_dbg             current FSM state (alu_state_e encoding)
module alu_seq_exec
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = 1;

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, op_in, step_op;
  logic [SHW-1:0]   cnt_q, cnt_d, shamt;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] core_res, step_src, step_val, imm_val;

  // One shift step; the sequencer applies this shamt times.
  function automatic logic [WIDTH-1:0] shift_one(alu_op_e sop, logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (sop)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign op_in = alu_op_e'(op);
  assign shamt = b[SHW-1:0];

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op  (op),
    .a   (a),
    .b   (b),
    .res (core_res)
  );

  // The accepting edge already performs the first shift step, so a shift by
  // shamt reaches DONE shamt edges after (and including) the accept edge.
  assign step_op  = (state_q == ST_SHIFT) ? op_q : op_in;
  assign step_src = (state_q == ST_SHIFT) ? result_q : a;
  assign step_val = shift_one(step_op, step_src);
  // Non-shift result, or a shift by zero which simply passes a through.
  assign imm_val  = is_shift(op_in) ? a : core_res;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op_in;
          if (is_shift(op_in) && (shamt != '0)) begin
            result_d = step_val;
            if (shamt == CNT_ONE) begin
              zero_d  = (step_val == '0);
              state_d = ST_DONE;
            end else begin
              cnt_d   = shamt - CNT_ONE;
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = imm_val;
            zero_d   = (imm_val == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        result_d = step_val;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          zero_d  = (step_val == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything and leaves the visible result untouched.
    if (flush) begin
      state_d  = ST_IDLE;
      op_d     = op_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (o)
      4'd0:  return x & y;
      4'd1:  return x ^ y;
      4'd2:  return x + y;
      4'd3:  return x << sh;
      4'd4:  return x >> sh;
      4'd5:  return x | y;
      4'd6:  return 32'($signed(x) >>> sh);
      4'd7:  return 32'(x < y);
      4'd8:  return 32'(x == y);
      4'd9:  return 32'(x != y);
      4'd10: return x - y;
      4'd11: return 32'($signed(x) < $signed(y));
      4'd12: return 32'($signed(x) < $signed(y));
      4'd13: return 32'($signed(x) >= $signed(y));
      4'd14: return 32'(x < y);
      default: return 32'(x >= y);
    endcase
  endfunction

  function automatic int ref_latency(logic [3:0] o, logic [31:0] y);
    if ((o == 4'd3 || o == 4'd4 || o == 4'd6) && y[4:0] != 5'd0) return int'(y[4:0]);
    return 1;
  endfunction

  // ---------------- driver: one full transaction ----------------
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name);
    logic [31:0] exp_r;
    int exp_lat;
    int lat;
    bit seen;
    exp_r   = ref_alu(o, x, y);
    exp_lat = ref_latency(o, y);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_before_issue: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, seen, exp_lat);
    end
    vectors++;
    if (result !== exp_r) begin
      miscompares++;
      $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", name, result, exp_r, o, x, y);
    end
    vectors++;
    if (zero !== (exp_r == 32'd0)) begin
      miscompares++;
      $display("FAIL %s zero: got %b want %b", name, zero, (exp_r == 32'd0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s return_idle: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 32'd0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: got in_ready=%b out_valid=%b busy=%b result=%h zero=%b want 1 0 0 0 1",
               in_ready, out_valid, busy, result, zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_op(4'd2,  32'd5,    32'd7,    "add_5_7");
    do_op(4'd10, 32'd3,    32'd5,    "sub_3_5");
    do_op(4'd1,  32'hA5,   32'hA5,   "xor_eq");
    do_op(4'd0,  32'hF0F0, 32'h0FF0, "and");
    do_op(4'd5,  32'hF000, 32'h000F, "or");
  endtask

  task automatic test_shift();
    do_op(4'd6, 32'h8000_0000, 32'd4,  "sra_4");
    do_op(4'd4, 32'h8000_0000, 32'd4,  "srl_4");
    do_op(4'd3, 32'h1234_5678, 32'd0,  "sll_0");
    do_op(4'd3, 32'h0000_0001, 32'd1,  "sll_1");
    do_op(4'd3, 32'h0000_0001, 32'd31, "sll_31");
    do_op(4'd6, 32'h8000_0000, 32'd31, "sra_31");
    do_op(4'd4, 32'h8000_0000, 32'hFFFF_FFE0, "srl_hi_bits_ignored");
  endtask

  task automatic test_compares();
    do_op(4'd11, 32'hFFFF_FFFF, 32'd1, "lt");
    do_op(4'd14, 32'hFFFF_FFFF, 32'd1, "ltu");
    do_op(4'd15, 32'hFFFF_FFFF, 32'd1, "geu");
    do_op(4'd12, 32'hFFFF_FFFF, 32'd1, "slt");
    do_op(4'd7,  32'hFFFF_FFFF, 32'd1, "sltu");
    do_op(4'd8,  32'hFFFF_FFFF, 32'd1, "eq");
    do_op(4'd9,  32'hFFFF_FFFF, 32'd1, "ne");
    do_op(4'd13, 32'hFFFF_FFFF, 32'd1, "ge");
    do_op(4'd8,  32'h55AA_55AA, 32'h55AA_55AA, "eq_equal");
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) y = x;
      do_op(o, x, y, "random");
    end
  endtask

  task automatic test_backpressure();
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1; op = 4'd2; a = 32'd100; b = 32'd23;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || result !== 32'd123 || zero !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc%0d: got out_valid=%b result=%h zero=%b in_ready=%b want 1 0000007b 0 0",
                 c, out_valid, result, zero, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    bit saw_valid;
    // flush on the third SHIFT cycle of SLL by 20
    @(negedge clk);
    in_valid = 1'b1; op = 4'd3; a = 32'h0000_0003; b = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);          // SHIFT cycle 1
    @(negedge clk);          // SHIFT cycle 2
    @(negedge clk);          // SHIFT cycle 3
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre_busy: got %b want 1", busy);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_to_idle: got busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
    saw_valid = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1;
    end
    vectors++;
    if (saw_valid) begin
      miscompares++;
      $display("FAIL flush_no_out_valid: got out_valid asserted want never");
    end
    // flush together with in_valid in IDLE: not accepted
    in_valid = 1'b1; flush = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_blocks_accept: got busy=%b out_valid=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_blocks_accept_late: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    in_valid = 1'b1; op = 4'd3; a = 32'h0000_00FF; b = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 32'd0 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got in_ready=%b out_valid=%b busy=%b result=%h zero=%b want 1 0 0 0 1",
               in_ready, out_valid, busy, result, zero);
    end
    @(negedge clk);
    reset = 1'b0;
    do_op(4'd2, 32'd40, 32'd2, "add_after_reset");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #1;
    test_reset();
    test_basic();
    test_shift();
    test_compares();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
